// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode command responder.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CMD,
        ST_NCR,
        ST_RESP
    } state_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    function automatic logic [7:0] r1_status(input logic idle, input logic illegal);
        logic [7:0] r1;
        r1 = 8'h00;
        r1[R1_IDLE_BIT]    = idle;
        r1[R1_ILLEGAL_BIT] = illegal;
        return r1;
    endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI slave byte engine: input synchronizers, SCLK edge detect,
// receive shifter with byte-done strobe, and a transmit shifter fed through a load port.
module spi_slave_byte #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       ss_inactive,
    output logic       miso
);

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic                   sclk_prev_reg;
    logic                   ss_prev_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             rx_reg;
    logic [7:0]             tx_reg;
    logic [7:0]             tx_next_reg;
    logic                   load_pending_reg;
    logic                   byte_done_reg;

    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_fall;

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign ss_fall   = ~ss_s & ss_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '1;
            mosi_sync_reg <= '1;
            ss_sync_reg   <= '1;
            sclk_prev_reg <= 1'b1;
            ss_prev_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_n};
            sclk_prev_reg <= sclk_s;
            ss_prev_reg   <= ss_s;
        end
    end

    // Deselect dominates any SCLK edge seen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg      <= 3'd0;
            rx_reg           <= 8'hFF;
            tx_reg           <= 8'hFF;
            tx_next_reg      <= 8'hFF;
            load_pending_reg <= 1'b0;
            byte_done_reg    <= 1'b0;
        end else if (ss_s) begin
            bit_cnt_reg      <= 3'd0;
            rx_reg           <= 8'hFF;
            tx_reg           <= 8'hFF;
            tx_next_reg      <= 8'hFF;
            load_pending_reg <= 1'b0;
            byte_done_reg    <= 1'b0;
        end else begin
            byte_done_reg <= 1'b0;
            if (load) begin
                tx_next_reg <= load_byte;
            end
            if (ss_fall) begin
                bit_cnt_reg      <= 3'd0;
                load_pending_reg <= 1'b0;
            end else if (sclk_rise) begin
                rx_reg      <= {rx_reg[6:0], mosi_s};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    byte_done_reg    <= 1'b1;
                    load_pending_reg <= 1'b1;
                end
            end else if (sclk_fall) begin
                // The fall after a completed byte presents the next byte's MSB.
                if (load_pending_reg) begin
                    tx_reg           <= tx_next_reg;
                    load_pending_reg <= 1'b0;
                end else begin
                    tx_reg <= {tx_reg[6:0], 1'b1};
                end
            end
        end
    end

    assign rx_byte     = rx_reg;
    assign byte_done   = byte_done_reg;
    assign ss_inactive = ss_s;
    assign miso        = ss_s | tx_reg[7];

endmodule

// File: rtl/sd_card_spi_responder.sv
// SD-card SPI-mode responder: frames 6-byte commands, answers with NCR filler
// then an R1 byte, and tracks the idle / application-command flags.
module sd_card_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_idle
);

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       ss_inactive;
    logic       load;
    logic [7:0] load_byte;

    state_t      state_reg, state_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic [5:0]  idx_reg, idx_next;
    logic [31:0] arg_reg, arg_next;
    logic        cmd_valid_reg, cmd_valid_next;
    logic [5:0]  cmd_index_reg, cmd_index_next;
    logic [31:0] cmd_arg_reg, cmd_arg_next;
    logic        idle_reg, idle_next;
    logic        app_reg, app_next;
    logic [7:0]  r1_reg, r1_next;

    spi_slave_byte #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_byte (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .sclk        (spi_sclk),
        .mosi        (spi_mosi),
        .ss_n        (spi_ss_n),
        .load        (load),
        .load_byte   (load_byte),
        .rx_byte     (rx_byte),
        .byte_done   (byte_done),
        .ss_inactive (ss_inactive),
        .miso        (spi_miso)
    );

    assign load = byte_done & ~ss_inactive;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg     <= ST_HUNT;
            byte_cnt_reg  <= 3'd0;
            idx_reg       <= 6'd0;
            arg_reg       <= 32'd0;
            cmd_valid_reg <= 1'b0;
            cmd_index_reg <= 6'd0;
            cmd_arg_reg   <= 32'd0;
            idle_reg      <= 1'b1;
            app_reg       <= 1'b0;
            r1_reg        <= FILL_BYTE;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            idx_reg       <= idx_next;
            arg_reg       <= arg_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_index_reg <= cmd_index_next;
            cmd_arg_reg   <= cmd_arg_next;
            idle_reg      <= idle_next;
            app_reg       <= app_next;
            r1_reg        <= r1_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        idx_next       = idx_reg;
        arg_next       = arg_reg;
        cmd_valid_next = 1'b0;
        cmd_index_next = cmd_index_reg;
        cmd_arg_next   = cmd_arg_reg;
        idle_next      = idle_reg;
        app_next       = app_reg;
        r1_next        = r1_reg;
        load_byte      = FILL_BYTE;

        if (ss_inactive) begin
            state_next    = ST_HUNT;
            byte_cnt_next = 3'd0;
        end else if (byte_done) begin
            case (state_reg)
                ST_HUNT: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        idx_next      = rx_byte[5:0];
                        byte_cnt_next = 3'd0;
                        state_next    = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_cnt_reg < 3'd4) begin
                        arg_next      = {arg_reg[23:0], rx_byte};
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                    end else begin
                        // CRC byte: accept the command; R1 uses pre-update flags.
                        state_next     = ST_NCR;
                        cmd_valid_next = 1'b1;
                        cmd_index_next = idx_reg;
                        cmd_arg_next   = arg_reg;
                        app_next       = 1'b0;
                        case (idx_reg)
                            CMD0: begin
                                r1_next   = r1_status(1'b1, 1'b0);
                                idle_next = 1'b1;
                            end
                            CMD55: begin
                                r1_next  = r1_status(idle_reg, 1'b0);
                                app_next = 1'b1;
                            end
                            ACMD41: begin
                                if (app_reg) begin
                                    r1_next   = r1_status(1'b0, 1'b0);
                                    idle_next = 1'b0;
                                end else begin
                                    r1_next = r1_status(idle_reg, 1'b1);
                                end
                            end
                            CMD8, CMD16, CMD17, CMD24: r1_next = r1_status(idle_reg, 1'b0);
                            default:                   r1_next = r1_status(idle_reg, 1'b1);
                        endcase
                    end
                end
                ST_NCR: begin
                    load_byte  = r1_reg;
                    state_next = ST_RESP;
                end
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd_index = cmd_index_reg;
    assign cmd_arg   = cmd_arg_reg;
    assign card_idle = idle_reg;

endmodule

// File: tb/tb_sd_card_spi_responder.sv
// Randomized frame-level bench for sd_card_spi_responder with a command-level card model.
module tb_sd_card_spi_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b1;
    logic        spi_ss_n = 1'b1;
    logic        spi_miso;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        card_idle;

    sd_card_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_ss_n      (spi_ss_n),
        .spi_miso      (spi_miso),
        .cmd_valid     (cmd_valid),
        .cmd_index     (cmd_index),
        .cmd_arg       (cmd_arg),
        .card_idle     (card_idle)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;
    int valid_count = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        idle;
    } exp_t;
    exp_t exp_q[$];

    // Card model: just the two flags and the R1 rules.
    logic m_idle = 1'b1;
    logic m_app  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, output logic [7:0] r1);
        int ix;
        ix = int'(idx);
        if (ix == 0) begin
            r1 = 8'h01;
            m_idle = 1'b1;
        end else if (ix == 41 && m_app) begin
            r1 = 8'h00;
            m_idle = 1'b0;
        end else if (ix == 55 || ix == 8 || ix == 16 || ix == 17 || ix == 24) begin
            r1 = m_idle ? 8'h01 : 8'h00;
        end else begin
            r1 = m_idle ? 8'h05 : 8'h04;
        end
        m_app = (ix == 55);
        exp_q.push_back('{idx, arg, m_idle});
    endtask

    // Compare process: every cycle out of reset, the command outputs and idle flag
    // must equal what the model says the last accepted command left behind.
    logic [5:0]  mon_idx = 6'd0;
    logic [31:0] mon_arg = 32'd0;
    logic        mon_idle = 1'b1;
    logic        prev_valid = 1'b0;
    always @(negedge clk_clk) begin
        exp_t e;
        if (!reset_reset_n) begin
            mon_idx = 6'd0;
            mon_arg = 32'd0;
            mon_idle = 1'b1;
            prev_valid = 1'b0;
        end else begin
            if (cmd_valid) begin
                valid_count++;
                check("valid_single_cycle", 32'(prev_valid), 32'd0);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cmd_valid actual=index %0d required=no pulse", cmd_index);
                end else begin
                    e = exp_q.pop_front();
                    mon_idx = e.idx;
                    mon_arg = e.arg;
                    mon_idle = e.idle;
                end
            end
            check("cmd_index_hold", 32'(cmd_index), 32'(mon_idx));
            check("cmd_arg_hold", cmd_arg, mon_arg);
            check("card_idle_track", 32'(card_idle), 32'(mon_idle));
            prev_valid = cmd_valid;
        end
    end

    task automatic half();
        repeat (8) @(posedge clk_clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'hFF;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            half();
            rx[7-i] = spi_miso;
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_ss_n = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        spi_ss_n = 1'b1;
        repeat (6) @(posedge clk_clk);
        #1;
        check("miso_deselected", 32'(spi_miso), 32'd1);
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        m_idle = 1'b1;
        m_app = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        repeat (4) @(posedge clk_clk);
        #1;
    endtask

    // Optional HUNT filler, 6 command bytes, then NCR and RESP byte slots.
    // abort_byte < 8 stops after abort_bits bits of that byte and deselects.
    task automatic send_frame(input logic [7:0] b0, input logic [31:0] arg, input logic [7:0] crc,
                              input int n_fill, input int abort_byte, input int abort_bits,
                              output logic [7:0] r1_obs);
        logic [7:0] fr [8];
        logic [7:0] rx, fill, exp_r1;
        fr[0] = b0;
        fr[1] = arg[31:24];
        fr[2] = arg[23:16];
        fr[3] = arg[15:8];
        fr[4] = arg[7:0];
        fr[5] = crc;
        fr[6] = 8'($urandom);
        fr[7] = 8'($urandom);
        exp_r1 = 8'hFF;
        r1_obs = 8'hFF;
        cs_low();
        for (int f = 0; f < n_fill; f++) begin
            fill = 8'($urandom);
            if (fill[7:6] == 2'b01) fill[7] = 1'b1;
            spi_bits(fill, 8, rx);
            check("miso_hunt_fill", 32'(rx), 32'hFF);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == abort_byte) begin
                spi_bits(fr[k], abort_bits, rx);
                break;
            end
            if (k == 5) model_cmd(b0[5:0], arg, exp_r1);
            spi_bits(fr[k], 8, rx);
            if (k < 7) check("miso_fill_byte", 32'(rx), 32'hFF);
            else begin
                check("miso_r1", 32'(rx), 32'(exp_r1));
                r1_obs = rx;
            end
        end
        cs_high();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1, rx;
        int vc0;
        logic [5:0] idx;
        logic [31:0] arg;
        int pick, ab;

        repeat (3) @(posedge clk_clk);
        #1;
        check("reset_miso", 32'(spi_miso), 32'd1);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_cmd_index", 32'(cmd_index), 32'd0);
        check("reset_cmd_arg", cmd_arg, 32'd0);
        check("reset_card_idle", 32'(card_idle), 32'd1);
        do_reset();

        // CMD0 then two filler bytes
        vc0 = valid_count;
        send_frame(8'h40, 32'h0, 8'h95, 0, 8, 0, r1);
        $display("tx CMD0 r1=%02h idx=%0d", r1, cmd_index);
        check("cmd0_r1", 32'(r1), 32'h01);
        check("cmd0_pulses", 32'(valid_count - vc0), 32'd1);
        check("cmd0_index", 32'(cmd_index), 32'd0);
        check("cmd0_idle", 32'(card_idle), 32'd1);

        // CMD55 then ACMD41
        send_frame(8'h77, 32'h0, 8'h65, 0, 8, 0, r1);
        $display("tx CMD55 r1=%02h", r1);
        check("cmd55_r1", 32'(r1), 32'h01);
        send_frame(8'h69, 32'h40000000, 8'h77, 1, 8, 0, r1);
        $display("tx ACMD41 r1=%02h idle=%0b", r1, card_idle);
        check("acmd41_r1", 32'(r1), 32'h00);
        check("acmd41_idle", 32'(card_idle), 32'd0);
        check("acmd41_arg", cmd_arg, 32'h40000000);

        // ACMD41 without preceding CMD55
        do_reset();
        send_frame(8'h69, 32'h40000000, 8'h77, 0, 8, 0, r1);
        $display("tx CMD41-no55 r1=%02h idle=%0b", r1, card_idle);
        check("no55_r1", 32'(r1), 32'h05);
        check("no55_idle", 32'(card_idle), 32'd1);

        // CMD17 with argument
        send_frame(8'h51, 32'h12345678, 8'hFF, 0, 8, 0, r1);
        $display("tx CMD17 r1=%02h idx=%0d arg=%08h", r1, cmd_index, cmd_arg);
        check("cmd17_index", 32'(cmd_index), 32'd17);
        check("cmd17_arg", cmd_arg, 32'h12345678);
        check("cmd17_r1", 32'(r1), 32'h01);

        // Deselect after 3 bits of byte 4, then a full CMD0
        vc0 = valid_count;
        send_frame(8'h40, 32'h0, 8'h95, 0, 3, 3, r1);
        $display("tx aborted-frame pulses=%0d", valid_count - vc0);
        check("abort_no_pulse", 32'(valid_count - vc0), 32'd0);
        check("abort_index_held", 32'(cmd_index), 32'd17);
        send_frame(8'h40, 32'h0, 8'h95, 0, 8, 0, r1);
        $display("tx CMD0-after-abort r1=%02h", r1);
        check("after_abort_r1", 32'(r1), 32'h01);
        check("after_abort_index", 32'(cmd_index), 32'd0);

        // Leave idle, then reset mid-RESP of a CMD17
        send_frame(8'h77, 32'h0, 8'h01, 0, 8, 0, r1);
        send_frame(8'h69, 32'h0, 8'h01, 0, 8, 0, r1);
        check("pre_reset_idle", 32'(card_idle), 32'd0);
        cs_low();
        for (int k = 0; k < 7; k++) begin
            if (k == 5) model_cmd(6'd17, 32'h0, r1);
            spi_bits((k == 0) ? 8'h51 : 8'h00, 8, rx);
        end
        spi_bits(8'h00, 3, rx);
        check("resp_bits_before_reset", 32'(rx[7:5]), 32'd0);
        reset_reset_n = 1'b0;
        #1;
        $display("tx reset-in-RESP miso=%0b idle=%0b", spi_miso, card_idle);
        check("reset_async_miso", 32'(spi_miso), 32'd1);
        check("reset_async_idle", 32'(card_idle), 32'd1);
        do_reset();
        send_frame(8'h48, 32'h000001AA, 8'h87, 0, 8, 0, r1);
        $display("tx CMD8-after-reset r1=%02h idx=%0d", r1, cmd_index);
        check("post_reset_r1", 32'(r1), 32'h01);
        check("post_reset_index", 32'(cmd_index), 32'd8);

        // Randomized command stream against the model
        for (int t = 0; t < 30; t++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: idx = 6'd0;
                1, 2: idx = 6'd55;
                3: idx = 6'd41;
                4: idx = 6'd8;
                5: idx = 6'd17;
                6: idx = 6'd24;
                default: idx = 6'($urandom);
            endcase
            arg = $urandom;
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 5) : 8;
            send_frame({2'b01, idx}, arg, 8'($urandom), $urandom_range(0, 2), ab,
                       $urandom_range(1, 7), r1);
            $display("tx rand idx=%0d arg=%08h abort=%0d r1=%02h idle=%0b",
                     idx, arg, ab, r1, card_idle);
        end

        repeat (10) @(posedge clk_clk);
        #1;
        check("all_expected_pulses_seen", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
